// File: rtl/cpu_pkg.sv
// Shared core types: default register/tag widths, the per-register status entry
// and the lookup response seen by the reservation stations.
package cpu_pkg;

    localparam int CPU_REG_W = 5;
    localparam int CPU_TAG_W = 4;

    typedef struct packed {
        logic                 busy;
        logic [CPU_TAG_W-1:0] tag;
    } status_entry_t;

    localparam status_entry_t STATUS_ENTRY_ZERO = '{busy: 1'b0, tag: '0};

    typedef struct packed {
        logic                 busy;
        logic [CPU_TAG_W-1:0] tag;
    } lookup_resp_t;

endpackage

// File: rtl/rst_entry_bypass.sv
// Post-processes one raw status-table read: range and zero-register masking,
// optional same-cycle commit bypass, and a kill input used for flush.
module rst_entry_bypass
    import cpu_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int REG_W     = CPU_REG_W,
    parameter int TAG_W     = CPU_TAG_W,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS_EN = 1
) (
    input  logic [REG_W-1:0] idx,
    input  logic             raw_busy,
    input  logic [TAG_W-1:0] raw_tag,
    input  logic             commit_valid,
    input  logic [REG_W-1:0] commit_reg,
    input  logic [TAG_W-1:0] commit_tag,
    input  logic             kill,
    output logic             busy,
    output logic [TAG_W-1:0] tag
);

    logic in_range;
    logic is_zero;
    logic committed;
    logic visible;

    assign in_range  = int'(idx) < NUM_REGS;
    assign is_zero   = (ZERO_REG != 0) && (idx == '0);
    // A commit retiring exactly this producer makes the value ready this cycle.
    assign committed = (BYPASS_EN != 0) && commit_valid
                       && (commit_reg == idx) && (commit_tag == raw_tag);
    assign visible   = raw_busy && in_range && !is_zero && !committed && !kill;

    assign busy = visible;
    assign tag  = visible ? raw_tag : '0;

endmodule

// File: rtl/reg_status_table.sv
// Register result-status table: per architectural register a pending flag and
// the producing ROB tag, with registered multi-port lookups and a debug probe.
module reg_status_table
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int REG_W    = CPU_REG_W,
    parameter int TAG_W    = CPU_TAG_W,
    parameter int NUM_SRC  = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     lookupValid,
    input  logic [NUM_SRC*REG_W-1:0] lookupReg,
    output logic                     respValid,
    output logic [NUM_SRC-1:0]       respBusy,
    output logic [NUM_SRC*TAG_W-1:0] respTag,
    input  logic                     issueValid,
    input  logic [REG_W-1:0]         issueReg,
    input  logic [TAG_W-1:0]         issueTag,
    input  logic                     commitValid,
    input  logic [REG_W-1:0]         commitReg,
    input  logic [TAG_W-1:0]         commitTag,
    input  logic                     flush,
    input  logic [REG_W-1:0]         probeReg,
    output logic                     probeBusy,
    output logic [TAG_W-1:0]         probeTag
);

    logic             busy_q [NUM_REGS];
    logic [TAG_W-1:0] tag_q  [NUM_REGS];

    logic [NUM_REGS-1:0] issue_hit;
    logic [NUM_REGS-1:0] commit_hit;

    logic [REG_W-1:0] lookup_idx [NUM_SRC];
    logic             raw_busy   [NUM_SRC];
    logic [TAG_W-1:0] raw_tag    [NUM_SRC];
    logic             probe_raw_busy;
    logic [TAG_W-1:0] probe_raw_tag;

    logic [NUM_SRC-1:0]       byp_busy;
    logic [NUM_SRC*TAG_W-1:0] byp_tag;

    always_comb begin
        issue_hit  = '0;
        commit_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            issue_hit[i]  = issueValid && (issueReg == REG_W'(i))
                            && !((ZERO_REG != 0) && (i == 0));
            commit_hit[i] = commitValid && (commitReg == REG_W'(i))
                            && busy_q[i] && (tag_q[i] == commitTag);
        end
    end

    // Issue is applied after commit so a same-register pair ends busy with the new tag.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                busy_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (issue_hit[i]) begin
                    busy_q[i] <= 1'b1;
                    tag_q[i]  <= issueTag;
                end else if (commit_hit[i]) begin
                    busy_q[i] <= 1'b0;
                    tag_q[i]  <= '0;
                end
            end
        end
    end

    // Mux-style reads keep out-of-range indices at zero instead of reading past the array.
    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            raw_busy[k] = 1'b0;
            raw_tag[k]  = '0;
            for (int j = 0; j < NUM_REGS; j++) begin
                if (lookup_idx[k] == REG_W'(j)) begin
                    raw_busy[k] = busy_q[j];
                    raw_tag[k]  = tag_q[j];
                end
            end
        end
        probe_raw_busy = 1'b0;
        probe_raw_tag  = '0;
        for (int j = 0; j < NUM_REGS; j++) begin
            if (probeReg == REG_W'(j)) begin
                probe_raw_busy = busy_q[j];
                probe_raw_tag  = tag_q[j];
            end
        end
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        assign lookup_idx[k] = lookupReg[k*REG_W +: REG_W];

        rst_entry_bypass #(
            .NUM_REGS (NUM_REGS),
            .REG_W    (REG_W),
            .TAG_W    (TAG_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS_EN(1)
        ) u_bypass (
            .idx         (lookup_idx[k]),
            .raw_busy    (raw_busy[k]),
            .raw_tag     (raw_tag[k]),
            .commit_valid(commitValid),
            .commit_reg  (commitReg),
            .commit_tag  (commitTag),
            .kill        (flush),
            .busy        (byp_busy[k]),
            .tag         (byp_tag[k*TAG_W +: TAG_W])
        );
    end

    rst_entry_bypass #(
        .NUM_REGS (NUM_REGS),
        .REG_W    (REG_W),
        .TAG_W    (TAG_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS_EN(0)
    ) u_probe (
        .idx         (probeReg),
        .raw_busy    (probe_raw_busy),
        .raw_tag     (probe_raw_tag),
        .commit_valid(1'b0),
        .commit_reg  ('0),
        .commit_tag  ('0),
        .kill        (1'b0),
        .busy        (probeBusy),
        .tag         (probeTag)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            respValid <= 1'b0;
            respBusy  <= '0;
            respTag   <= '0;
        end else begin
            respValid <= lookupValid;
            if (lookupValid) begin
                respBusy <= byp_busy;
                respTag  <= byp_tag;
            end
        end
    end

endmodule

// File: tb/tb_reg_status_table.sv
// Self-checking bench for reg_status_table (NUM_REGS=24 so out-of-range indices
// are reachable); lookup expectations are queued at drive time and popped on response.
module tb_reg_status_table;

    localparam int NREGS = 24;
    localparam int REG_W = 5;
    localparam int TAG_W = 4;
    localparam int NSRC  = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    lookupValid = 1'b0;
    logic [NSRC*REG_W-1:0]   lookupReg = '0;
    logic                    respValid;
    logic [NSRC-1:0]         respBusy;
    logic [NSRC*TAG_W-1:0]   respTag;
    logic                    issueValid = 1'b0;
    logic [REG_W-1:0]        issueReg = '0;
    logic [TAG_W-1:0]        issueTag = '0;
    logic                    commitValid = 1'b0;
    logic [REG_W-1:0]        commitReg = '0;
    logic [TAG_W-1:0]        commitTag = '0;
    logic                    flush = 1'b0;
    logic [REG_W-1:0]        probeReg = '0;
    logic                    probeBusy;
    logic [TAG_W-1:0]        probeTag;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [NSRC-1:0]       b;
        logic [NSRC*TAG_W-1:0] t;
    } resp_t;

    resp_t sb[$];
    resp_t last_r = '0;

    bit         m_busy [32];
    logic [3:0] m_tag  [32];

    always #50 clk = ~clk;

    reg_status_table #(
        .NUM_REGS(NREGS),
        .REG_W   (REG_W),
        .TAG_W   (TAG_W),
        .NUM_SRC (NSRC),
        .ZERO_REG(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookupValid(lookupValid),
        .lookupReg  (lookupReg),
        .respValid  (respValid),
        .respBusy   (respBusy),
        .respTag    (respTag),
        .issueValid (issueValid),
        .issueReg   (issueReg),
        .issueTag   (issueTag),
        .commitValid(commitValid),
        .commitReg  (commitReg),
        .commitTag  (commitTag),
        .flush      (flush),
        .probeReg   (probeReg),
        .probeBusy  (probeBusy),
        .probeTag   (probeTag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void exp_lookup(input int r, output bit b, output logic [3:0] t);
        b = 1'b0;
        t = 4'h0;
        if (flush || r >= NREGS || r == 0 || !m_busy[r]) return;
        if (commitValid && int'(commitReg) == r && m_tag[r] == commitTag) return;
        b = 1'b1;
        t = m_tag[r];
    endfunction

    function automatic void exp_probe(input int r, output bit b, output logic [3:0] t);
        b = 1'b0;
        t = 4'h0;
        if (r >= NREGS || r == 0 || !m_busy[r]) return;
        b = 1'b1;
        t = m_tag[r];
    endfunction

    task automatic model_update();
        int cr;
        int ir;
        cr = int'(commitReg);
        ir = int'(issueReg);
        if (!rst_n || flush) begin
            for (int i = 0; i < 32; i++) begin
                m_busy[i] = 1'b0;
                m_tag[i]  = 4'h0;
            end
        end else begin
            if (commitValid && cr < NREGS && m_busy[cr] && m_tag[cr] == commitTag) begin
                m_busy[cr] = 1'b0;
                m_tag[cr]  = 4'h0;
            end
            if (issueValid && ir < NREGS && ir != 0) begin
                m_busy[ir] = 1'b1;
                m_tag[ir]  = issueTag;
            end
        end
    endtask

    task automatic check_probe();
        bit b;
        logic [3:0] t;
        exp_probe(int'(probeReg), b, t);
        check("probe_busy", 32'(probeBusy), 32'(b));
        check("probe_tag", 32'(probeTag), 32'(t));
    endtask

    // One clock: queue the lookup expectation, advance, then compare at the falling edge.
    task automatic tick();
        resp_t e;
        bit ev;
        bit b;
        bit was_reset;
        logic [3:0] t;
        e = '0;
        ev = lookupValid && rst_n;
        was_reset = !rst_n;
        if (ev) begin
            for (int k = 0; k < NSRC; k++) begin
                exp_lookup(int'(lookupReg[k*REG_W +: REG_W]), b, t);
                e.b[k] = b;
                e.t[k*TAG_W +: TAG_W] = t;
            end
            sb.push_back(e);
        end
        @(posedge clk);
        model_update();
        if (was_reset) last_r = '0;
        @(negedge clk);
        check("resp_valid", 32'(respValid), 32'(ev));
        if (respValid) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("resp_busy", 32'(respBusy), 32'(e.b));
                check("resp_tag", 32'(respTag), 32'(e.t));
                last_r = e;
            end
        end else begin
            check("hold_busy", 32'(respBusy), 32'(last_r.b));
            check("hold_tag", 32'(respTag), 32'(last_r.t));
        end
        check_probe();
        lookupValid = 1'b0;
        issueValid  = 1'b0;
        commitValid = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic do_lookup(input int r0, input int r1);
        lookupValid = 1'b1;
        lookupReg   = {5'(r1), 5'(r0)};
    endtask

    task automatic do_issue(input int r, input int t);
        issueValid = 1'b1;
        issueReg   = 5'(r);
        issueTag   = 4'(t);
    endtask

    task automatic do_commit(input int r, input int t);
        commitValid = 1'b1;
        commitReg   = 5'(r);
        commitTag   = 4'(t);
    endtask

    task automatic probe_all();
        for (int r = 0; r < 32; r++) begin
            probeReg = 5'(r);
            #1;
            check_probe();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_busy[i] = 1'b0;
            m_tag[i]  = 4'h0;
        end

        // reset, including a lookup held during reset
        do_lookup(3, 7);
        tick();
        tick();
        rst_n = 1'b1;

        // 1: lookups after reset
        do_lookup(3, 7);
        probeReg = 5'd3;
        tick();

        // 2: WAW rename and tag-checked commit
        do_issue(5, 4);
        tick();
        do_lookup(5, 3);
        probeReg = 5'd5;
        tick();
        do_issue(5, 9);
        tick();
        do_commit(5, 4);
        do_lookup(3, 5);
        tick();
        do_commit(5, 9);
        tick();
        do_lookup(5, 5);
        tick();

        // 3: issue vs lookup, issue vs commit in the same cycle
        do_issue(2, 6);
        do_lookup(2, 2);
        probeReg = 5'd2;
        tick();
        do_lookup(2, 5);
        tick();
        do_issue(2, 7);
        do_commit(2, 6);
        tick();
        do_lookup(2, 0);
        tick();

        // 4: commit bypass
        do_issue(4, 3);
        tick();
        do_lookup(4, 2);
        do_commit(4, 3);
        probeReg = 5'd4;
        tick();
        tick();

        // 5: flush beats issue and lookup
        for (int r = 1; r <= 10; r++) begin
            do_issue(r, r + 3);
            tick();
        end
        do_lookup(7, 10);
        tick();
        flush = 1'b1;
        do_issue(11, 2);
        do_lookup(1, 11);
        tick();
        probe_all();
        do_lookup(11, 1);
        tick();

        // 6: zero register, range boundary, reset during lookup
        do_issue(0, 5);
        probeReg = 5'd0;
        tick();
        do_issue(23, 1);
        probeReg = 5'd23;
        tick();
        do_issue(24, 2);
        probeReg = 5'd24;
        tick();
        do_issue(30, 3);
        probeReg = 5'd30;
        tick();
        do_commit(30, 3);
        do_lookup(30, 23);
        tick();
        do_lookup(0, 24);
        tick();
        do_lookup(23, 23);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        do_lookup(23, 2);
        tick();

        // mixed random traffic
        for (int c = 0; c < 400; c++) begin
            int sel;
            int cr;
            sel = int'($urandom_range(0, 99));
            rst_n = (sel != 99);
            flush = (sel < 3);
            if ($urandom_range(0, 1) == 1) do_issue(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) begin
                cr = int'($urandom_range(0, 25));
                if ($urandom_range(0, 3) != 0) do_commit(cr, int'(m_tag[cr]));
                else do_commit(cr, int'($urandom_range(0, 15)));
            end
            if ($urandom_range(0, 2) != 0) do_lookup(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
            probeReg = 5'($urandom_range(0, 31));
            tick();
        end
        rst_n = 1'b1;
        tick();
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_status_table.md
Name: reg_status_table

Overview:
- Clocked, parametrised register result-status table for the Tomasulo/ROB core.
- Tracks, per architectural register, whether a result is pending and which ROB tag will produce it.
- Serves NUM_SRC source-operand lookups per issue with registered responses.
- Adds tag-checked commit clear, full flush on mispredict, commit bypass, a hardwired zero register and a debug probe port.

Parameters:
NUM_REGS, 32, architectural register count (need not be a power of 2)
REG_W, 5, register index width; must satisfy 2**REG_W >= NUM_REGS
TAG_W, 4, ROB tag width (ROB depth = 2**TAG_W)
NUM_SRC, 2, source-operand lookup ports
ZERO_REG, 1, 1 = register 0 is never marked busy

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
lookupValid  in  1  lookup request for this cycle
lookupReg  in  NUM_SRC*REG_W  packed source register indices; port k at bits [k*REG_W +: REG_W]
respValid  out  1  lookup response valid
respBusy  out  NUM_SRC  per-source pending flag
respTag  out  NUM_SRC*TAG_W  per-source producing ROB tag; 0 when not busy
issueValid  in  1  allocate destination register
issueReg  in  REG_W  destination register
issueTag  in  TAG_W  ROB tag of the issuing instruction
commitValid  in  1  ROB commit
commitReg  in  REG_W  committed destination register
commitTag  in  TAG_W  committed ROB tag
flush  in  1  mispredict or exception squash
probeReg  in  REG_W  debug query index (combinational)
probeBusy  out  1  busy bit of probeReg
probeTag  out  TAG_W  tag of probeReg; 0 if not busy

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low on rst_n; it is sampled only at posedge clk.
- Reset values: all busy bits 0, all tags 0, respValid 0, respBusy 0, respTag 0.
- Storage: per register, one busy bit and one TAG_W tag. There is no magic invalid-tag encoding; busy=0 means the value is ready in the register file.
- Lookup latency:
  - lookupValid at cycle N gives respValid=1 at N+1, with respBusy and respTag reflecting table state at the start of N, adjusted by the rules below.
  - respValid is 0 in any cycle not preceded by lookupValid.
  - respBusy and respTag hold their last values while respValid is 0.
- Issue: at posedge with issueValid, status[issueReg] becomes busy with issueTag, overwriting any older pending tag (WAW rename).
- Commit: at posedge with commitValid, status[commitReg] is cleared only if it is busy and its tag equals commitTag. On a tag mismatch the entry is untouched (a newer writer exists).
- Issue and commit in the same cycle, same register: issue wins, so the entry ends busy with issueTag.
- Lookup and issue in the same cycle: lookup returns the pre-issue state. The issuing instruction's own sources must not see its own destination.
- Lookup and commit in the same cycle, matching reg and tag: the response reports busy=0 and tag=0 (commit bypass).
- Flush:
  - At posedge with flush, all busy bits and tags clear.
  - issueValid and commitValid in the same cycle are ignored.
  - A lookup in the flush cycle responds with respValid=1 and all respBusy=0.
  - Flush has priority over everything except reset.
- Zero register: with ZERO_REG=1, issues to register 0 are ignored and lookups and probes of register 0 return not busy.
- Out-of-range indices (>= NUM_REGS):
  - Lookups and probes return busy=0, tag=0.
  - Issue and commit to such indices are ignored.
  - No X propagation.
- Reset mid-operation: rst_n=0 overrides flush, issue, commit and lookup. respValid is 0 in the cycle after a reset cycle even if lookupValid was high.
- Probe is purely combinational from current table state with no bypass. It is intended for the testbench and for ROB debug.

Decomposition:
- Shared package (cpu_pkg):
  - REG_W and TAG_W defaults
  - the status-entry struct {busy, tag}
  - a zero-entry constant
  - the lookup-response struct, reused by the reservation stations
- Sub-module: rst_entry_bypass. This is one combinational instance per source port that applies the commit-bypass and range/zero-register rules to a raw table read. Instantiate it NUM_SRC times plus once for the probe, with bypass disabled for the probe.

Test Plan:
1. Reset, then lookup r3 and r7 -> next cycle respValid=1, respBusy=2'b00, respTag=0; probe of r3 gives busy=0.
2. Issue r5 tag 4, then lookup r5 -> busy=1, tag=4. Issue r5 tag 9, then commit r5 tag 4 -> r5 stays busy with tag 9. Commit r5 tag 9 -> not busy.
3. Same cycle: issue r2 tag 6 and lookup r2 -> response busy=0. A lookup on the next cycle -> busy=1, tag=6. Same cycle: issue r2 tag 7 and commit r2 tag 6 -> r2 ends busy with tag 7.
4. r4 busy with tag 3; same cycle: lookup r4 and commit r4 tag 3 -> response busy=0, tag=0.
5. Fill r1..r10 busy, then pulse flush together with issue r11 tag 2 and a lookup of r1 -> response busy=0. On following cycles all probes are 0 and r11 is not busy.
6. ZERO_REG=1, issue r0 tag 5 -> r0 probe busy=0. With NUM_REGS=24, issue r30 -> ignored and probe r30 returns busy=0. Drive rst_n low during a lookup -> respValid=0 on the next cycle.
